// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for a single-port
// async-read memory; each port has a one-deep request slot and a registered valid pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rdy,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_spo
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_DM} state_t;
  typedef enum logic {LAST_IF = 1'b0, LAST_DM = 1'b1} port_t;

  state_t            state_q, state_d;
  port_t             last_q, last_d;
  logic              if_pend_q, if_pend_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic              dm_pend_q, dm_pend_d;
  logic              dm_we_q, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= LAST_DM;
      if_pend_q  <= 1'b0;
      if_addr_q  <= '0;
      dm_pend_q  <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      if_pend_q  <= if_pend_d;
      if_addr_q  <= if_addr_d;
      dm_pend_q  <= dm_pend_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
    end
  end

  // Arbitration looks at the slots as they will be after this edge's accepts and clears.
  always_comb begin
    if_pend_d  = if_pend_q;
    if_addr_d  = if_addr_q;
    dm_pend_d  = dm_pend_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    last_d     = last_q;
    state_d    = IDLE;

    if (if_req && !if_pend_q) begin
      if_pend_d = 1'b1;
      if_addr_d = if_addr;
    end
    if (dm_req && !dm_pend_q) begin
      dm_pend_d  = 1'b1;
      dm_we_d    = dm_we;
      dm_addr_d  = dm_addr;
      dm_wdata_d = dm_wdata;
    end

    case (state_q)
      ACC_IF: begin
        if_pend_d = 1'b0;
        last_d    = LAST_IF;
      end
      ACC_DM: begin
        dm_pend_d = 1'b0;
        last_d    = LAST_DM;
      end
      default: ;
    endcase

    if (if_pend_d && dm_pend_d) state_d = (last_d == LAST_DM) ? ACC_IF : ACC_DM;
    else if (if_pend_d)         state_d = ACC_IF;
    else if (dm_pend_d)         state_d = ACC_DM;
  end

  always_comb begin
    mem_a      = '0;
    mem_d      = '0;
    mem_we     = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    case (state_q)
      ACC_IF: begin
        mem_a      = if_addr_q;
        if_rdata_d = mem_spo;
        if_valid_d = 1'b1;
      end
      ACC_DM: begin
        mem_a      = dm_addr_q;
        dm_valid_d = 1'b1;
        if (dm_we_q) begin
          mem_we = 1'b1;
          mem_d  = dm_wdata_q;
        end else begin
          dm_rdata_d = mem_spo;
        end
      end
      default: ;
    endcase
  end

  assign if_rdy   = !if_pend_q;
  assign dm_rdy   = !dm_pend_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign if_valid = if_valid_q;
  assign dm_valid = dm_valid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port 1024x16 distributed memory (async read `spo`, write on `clk` rising edge when `we`=1). It sits between the instruction-fetch unit and the load/store unit of the processor. Each port gets a buffered one-request slot. The block shares the memory round-robin, one access per cycle, and returns read data with a registered valid pulse.

## Interface
- `ADDR_W`, default 10, memory address width (1024 words).
- `DATA_W`, default 16, memory word width.

- `clk`  input  1  system clock; all state updates on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `if_req`  input  1  fetch read request; sampled only when `if_rdy`=1.
- `if_addr`  input  ADDR_W  fetch address, sampled with `if_req`.
- `if_rdy`  output  1  fetch slot empty, request can be accepted.
- `if_rdata`  output  DATA_W  fetch read data, registered.
- `if_valid`  output  1  one-cycle pulse, `if_rdata` is valid.
- `dm_req`  input  1  data request; sampled only when `dm_rdy`=1.
- `dm_we`  input  1  1 = write, 0 = read; sampled with `dm_req`.
- `dm_addr`  input  ADDR_W  data address.
- `dm_wdata`  input  DATA_W  write data.
- `dm_rdy`  output  1  data slot empty.
- `dm_rdata`  output  DATA_W  data read result, registered.
- `dm_valid`  output  1  one-cycle completion pulse for reads and writes.
- `mem_a`  output  ADDR_W  to memory `a`.
- `mem_d`  output  DATA_W  to memory `d`.
- `mem_we`  output  1  to memory `we`.
- `mem_spo`  input  DATA_W  from memory `spo`.

## Operation
- Each port has a pending slot: a flag plus latched address, and for the data port also `we` and `wdata`. `x_rdy` = !pending_x.
- A request is accepted at an edge where `x_req`=1 and `x_rdy`=1. The slot's fields latch at that edge. Requests while `x_rdy`=0 are ignored and not queued.
- FSM states: IDLE, ACC_IF, ACC_DM. The state is registered and selects which slot drives the memory during the current cycle.
- Next state at each edge is computed from the slots after that edge's accepts and clears:
  - neither pending -> IDLE;
  - one pending -> that port's ACC state;
  - both pending -> the port not served last (round-robin pointer `last`).
- ACC_IF: `mem_a`=if slot addr, `mem_we`=0.
  - End of cycle: `if_rdata` <= `mem_spo`, `if_valid` <= 1, clear fetch slot, `last` <= IF.
- ACC_DM read: `mem_a`=dm addr, `mem_we`=0.
  - End of cycle: `dm_rdata` <= `mem_spo`, `dm_valid` <= 1, clear slot, `last` <= DM.
- ACC_DM write: `mem_a`=dm addr, `mem_d`=dm wdata, `mem_we`=1.
  - Memory writes at the end-of-cycle edge. `dm_valid` <= 1 and `dm_rdata` holds its previous value.
- IDLE: `mem_we`=0, `mem_a`=0, `mem_d`=0.
- `mem_we` is decoded from the state register only. It is never 1 outside ACC_DM with a latched write.
- `x_valid` is 1 for exactly one cycle per accepted request.
- No address arithmetic and no wrap. Addresses pass through unchanged; every value 0..1023 is legal.

## Timing
- Reset values (async, immediate): state IDLE; both slots empty (`if_rdy`=`dm_rdy`=1); `if_valid`=`dm_valid`=0; `if_rdata`=`dm_rdata`=0; `last`=DM, so fetch wins the first tie; `mem_we`=0, `mem_a`=0, `mem_d`=0.
- Latency: request accepted at edge E0 -> access cycle E0..E1 -> `x_valid`=1 in cycle E1..E2. Request-to-valid is 2 cycles when uncontended, 3 when the port loses arbitration.
- `x_rdy` returns to 1 in the cycle after the access cycle, the same cycle `x_valid` is high. A new request may be accepted at the edge ending that cycle. Per-port throughput is therefore one request per 2 cycles; aggregate throughput is 1 access per cycle when both ports are loaded.
- Simultaneous accepts on both ports at one edge: the tie is resolved by `last`, and the loser is served in the immediately following cycle.
- Round-robin bounds waiting: no port waits more than one extra access cycle.
- Reset asserted mid-access aborts the access.
  - `mem_we` drops asynchronously, so a write whose edge has not occurred is not performed.
  - No valid pulse is produced, pending slots are discarded, and outputs take their reset values.
- Reset deassertion is assumed synchronous to `clk` externally. The first accept is possible at the first edge with `reset_n`=1.

## Test plan
- Reset with `reset_n`=0 mid-stream -> both `rdy`=1, both `valid`=0, `rdata`=0, `mem_we`=0 immediately, without waiting for a clock edge.
- Data write 0xFFFF to addr 1, then fetch read of addr 1:
  - `mem_we`=1 for exactly one cycle with `mem_a`=1;
  - `dm_valid` pulses 2 cycles after accept;
  - `if_rdata`=0xFFFF with `if_valid` 2 cycles after its accept.
- Same-edge fetch read of addr 3 and data read of addr 11 (preloaded 0x2222 and 0xEFAB) after reset:
  - ACC_IF first, so `if_valid` appears with `if_rdata`=0x2222;
  - `dm_valid` one cycle later with `dm_rdata`=0xEFAB.
- Both ports re-requesting every time `rdy`=1 for 20 cycles -> grants strictly alternate IF/DM; each port gets 10 accesses; no `valid` pulse is longer than 1 cycle.
- Data request held while `dm_rdy`=0 with a changing address (5, then 6) -> only the address latched at accept (5) reaches `mem_a`, and exactly one `dm_valid` pulse results.
- `reset_n` asserted during an ACC_DM write cycle to addr 0 holding 0x0000, writing 0x1234 -> the later read of addr 0 returns 0x0000, and no `dm_valid` pulse occurs.
